// File: rtl/ann_sweep_checker.sv
// Self-test sequencer for the mine-detecting net: sweeps all 16 switch patterns,
// samples both indicators and scores them against a golden table. Optional abort: ANN_SWEEP_ABORT_EN.
module ann_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [31:0] EXPECTED      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef ANN_SWEEP_ABORT_EN
    input  logic        abort,
    output logic        aborted,
`endif
    output logic [3:0]  sw_out,
    input  logic [1:0]  led_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] captured,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

    function automatic logic [1:0] pair_at(input logic [31:0] word, input logic [3:0] i);
        return word[{i, 1'b0} +: 2];
    endfunction

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [3:0]  sw_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [31:0] captured_q;
    logic [4:0]  mismatch_q;
    logic [3:0]  ffi_q;
    logic        ffv_q;
`ifdef ANN_SWEEP_ABORT_EN
    logic        aborted_q;
`endif

    logic        sample_s;
    logic        miss_s;
    logic        abort_s;
    logic [4:0]  mismatch_d;

    // Sample-edge decode and the post-sample mismatch count
    always_comb begin
        sample_s   = (state_q == ST_RUN) && (cnt_q == SETTLE_LAST);
        miss_s     = (led_in != pair_at(EXPECTED, idx_q));
        mismatch_d = mismatch_q + {4'd0, miss_s};
`ifdef ANN_SWEEP_ABORT_EN
        abort_s    = abort && (state_q == ST_RUN);
`else
        abort_s    = 1'b0;
`endif
    end

    // Sweep FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            cnt_q      <= 8'd0;
            sw_q       <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= 32'd0;
            mismatch_q <= 5'd0;
            ffi_q      <= 4'd0;
            ffv_q      <= 1'b0;
`ifdef ANN_SWEEP_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        idx_q      <= 4'd0;
                        cnt_q      <= 8'd0;
                        sw_q       <= 4'd0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        captured_q <= 32'd0;
                        mismatch_q <= 5'd0;
                        ffi_q      <= 4'd0;
                        ffv_q      <= 1'b0;
`ifdef ANN_SWEEP_ABORT_EN
                        aborted_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        // Partial results are kept; the pending sample is dropped
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        sw_q      <= 4'd0;
`ifdef ANN_SWEEP_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (!sample_s) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        captured_q[{idx_q, 1'b0} +: 2] <= led_in;
                        mismatch_q <= mismatch_d;
                        if (miss_s && !ffv_q) begin
                            ffi_q <= idx_q;
                            ffv_q <= 1'b1;
                        end else begin
                            ffv_q <= ffv_q;
                        end
                        if (idx_q != 4'd15) begin
                            idx_q <= idx_q + 4'd1;
                            sw_q  <= idx_q + 4'd1;
                            cnt_q <= 8'd0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            sw_q    <= 4'd0;
                            pass_q  <= (mismatch_d == 5'd0);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    sw_q    <= 4'd0;
                end
            endcase
        end
    end

    assign sw_out           = sw_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign captured         = captured_q;
    assign mismatch_count   = mismatch_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;
`ifdef ANN_SWEEP_ABORT_EN
    assign aborted          = aborted_q;
`endif

endmodule

// File: tb/tb_ann_sweep_checker.sv
// Scoreboard bench for ann_sweep_checker: a fault-injecting net model drives led_in,
// a reference model predicts each sweep's results and a monitor compares them on done.
module tb_ann_sweep_checker;

    localparam int          S    = 4;
    localparam logic [31:0] GOLD = 32'hFE54_5454;

    typedef struct packed {
        logic [31:0] cap;
        logic [4:0]  cnt;
        logic [3:0]  ffi;
        logic        ffv;
        logic        pass;
    } res_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  sw_out;
    logic [1:0]  led_in;
    logic        busy, done, pass, first_fail_valid;
    logic [31:0] captured;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;
`ifdef ANN_SWEEP_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    logic        start_z = 1'b0;
    logic [3:0]  sw_z;
    logic [1:0]  led_z;
    logic        busy_z, done_z, pass_z, ffv_z;
    logic [31:0] cap_z;
    logic [4:0]  mm_z;
    logic [3:0]  ffi_z;

    logic [31:0] flip = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          e0 = 0;
    res_t        sb_q[$];
    int          cyc_q[$];

    function automatic logic [1:0] net(input logic [3:0] s);
        return {s[3] & s[2], s[1] | s[0]};
    endfunction

    function automatic logic [1:0] pick(input logic [31:0] w, input int i);
        return 2'((w >> (2 * i)) & 32'd3);
    endfunction

    // Reference: plays the first n patterns through the faulty net and scores them
    function automatic res_t ref_model(input logic [31:0] f, input int n);
        res_t r;
        logic [1:0] resp;
        r = '0;
        for (int i = 0; i < n; i++) begin
            resp  = net(4'(i)) ^ pick(f, i);
            r.cap = r.cap | (32'(resp) << (2 * i));
            if (resp != pick(GOLD, i)) begin
                r.cnt = r.cnt + 5'd1;
                if (!r.ffv) begin
                    r.ffi = 4'(i);
                    r.ffv = 1'b1;
                end
            end
        end
        r.pass = (n == 16) && (r.cnt == 5'd0);
        return r;
    endfunction

    assign led_in = net(sw_out) ^ pick(flip, int'(sw_out));
    assign led_z  = net(sw_z);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ann_sweep_checker #(.SETTLE_CYCLES(S), .EXPECTED(GOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ANN_SWEEP_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .sw_out(sw_out), .led_in(led_in), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch_count(mismatch_count),
        .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
    );

    ann_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(GOLD)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z),
`ifdef ANN_SWEEP_ABORT_EN
        .abort(1'b0), .aborted(),
`endif
        .sw_out(sw_z), .led_in(led_z), .busy(busy_z), .done(done_z), .pass(pass_z),
        .captured(cap_z), .mismatch_count(mm_z),
        .first_fail_idx(ffi_z), .first_fail_valid(ffv_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pattern hold timing while busy, full result compare on every done
    always @(negedge clk) begin
        res_t e;
        int   ec;
        if (rst_n) begin
            if (busy) check("sw_hold", 32'(sw_out), 32'((cyc - e0) / (S + 1)));
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e  = sb_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("done_latency", 32'(cyc), 32'(ec));
                    check("captured", captured, e.cap);
                    check("mismatch_count", 32'(mismatch_count), 32'(e.cnt));
                    check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
                    check("first_fail_valid", 32'(first_fail_valid), 32'(e.ffv));
                    check("pass", 32'(pass), 32'(e.pass));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("sw_at_done", 32'(sw_out), 32'd0);
                end
            end
        end
    end

    task automatic launch(input logic [31:0] f, input bit expect_done);
        flip = f;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0 = cyc;
        if (expect_done) begin
            sb_q.push_back(ref_model(f, 16));
            cyc_q.push_back(cyc + 16 * (S + 1));
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && (sb_q.size() != 0 || busy); k++) @(negedge clk);
        if (sb_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=pending required=complete");
            sb_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic wait_pattern(input logic [3:0] p);
        for (int k = 0; k < 200 && sw_out != p; k++) @(negedge clk);
        check("reach_pattern", 32'(sw_out), 32'(p));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_sw"}, 32'(sw_out), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_captured"}, captured, 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch_count), 32'd0);
        check({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
        check({tag, "_ffv"}, 32'(first_fail_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] f;
        res_t        r;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Golden pass and the single injected fault on pattern 5
        launch(32'd0, 1'b1);
        wait_idle();
        check("golden_word", captured, 32'hFE54_5454);
        launch(32'h0000_0400, 1'b1);
        wait_idle();
        check("fault5_word", captured, 32'hFE54_5054);
        repeat (6) @(negedge clk);
        check("idle_hold_captured", captured, 32'hFE54_5054);
        check("idle_hold_mismatch", 32'(mismatch_count), 32'd1);

        // Randomised fault patterns, including an all-wrong sweep
        for (int n = 0; n < 6; n++) begin
            f = (n == 5) ? 32'hFFFF_FFFF : ($urandom & $urandom & $urandom);
            launch(f, 1'b1);
            wait_idle();
        end

        // Start held through a whole sweep: ignored while busy, re-accepted on done
        flip = $urandom & $urandom;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        sb_q.push_back(ref_model(flip, 16));
        cyc_q.push_back(cyc + 16 * (S + 1));
        for (int k = 0; k < 200 && !done; k++) @(negedge clk);
        check("held_done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        e0 = cyc;
        sb_q.push_back(ref_model(flip, 16));
        cyc_q.push_back(cyc + 16 * (S + 1));
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_captured", captured, 32'd0);
        check("restart_mismatch", 32'(mismatch_count), 32'd0);
        check("restart_ffv", 32'(first_fail_valid), 32'd0);
        wait_idle();

        // Zero settle: one cycle per pattern, done 16 cycles after start
        @(negedge clk);
        start_z = 1'b1;
        @(posedge clk);
        #1;
        start_z = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("z_sw_step", 32'(sw_z), 32'(k));
            check("z_busy", 32'(busy_z), 32'd1);
            check("z_no_done", 32'(done_z), 32'd0);
        end
        @(negedge clk);
        r = ref_model(32'd0, 16);
        check("z_done", 32'(done_z), 32'd1);
        check("z_busy_end", 32'(busy_z), 32'd0);
        check("z_sw_end", 32'(sw_z), 32'd0);
        check("z_captured", cap_z, r.cap);
        check("z_pass", 32'(pass_z), 32'(r.pass));
        check("z_mismatch", 32'(mm_z), 32'(r.cnt));
        @(negedge clk);
        check("z_done_pulse", 32'(done_z), 32'd0);

        // Asynchronous reset while pattern 7 is applied
        launch($urandom | 32'h0000_0003, 1'b0);
        wait_pattern(4'd7);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_sw", 32'(sw_out), 32'd0);

`ifdef ANN_SWEEP_ABORT_EN
        // Abort during pattern 9 keeps results of patterns 0..8 only
        f = $urandom | 32'h0000_0001;
        launch(f, 1'b0);
        wait_pattern(4'd9);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        r = ref_model(f, 9);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_flag", 32'(aborted), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_sw", 32'(sw_out), 32'd0);
        check("abort_mismatch", 32'(mismatch_count), 32'(r.cnt));
        check("abort_captured", captured, r.cap);
        check("abort_ffv", 32'(first_fail_valid), 32'(r.ffv));
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ignored", 32'(aborted), 32'd1);
        launch(32'd0, 1'b1);
        check("abort_cleared", 32'(aborted), 32'd0);
        wait_idle();
`endif

        launch($urandom & $urandom, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
